// File: rtl/mc14512_scan_ctrl.sv
// Scan controller for one mc14512 8-channel selector: free-running debounced
// input image plus a priority single-channel direct read port.
module mc14512_scan_ctrl #(
  parameter int SETTLE   = 2,
  parameter int DEBOUNCE = 3
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       en,
  output logic [2:0] abc,
  output logic       inh,
  output logic       dis,
  input  logic       z,
  input  logic       rd_req,
  input  logic [2:0] rd_addr,
  output logic       rd_ack,
  output logic       rd_data,
  output logic [7:0] image,
  output logic       scan_done,
  output logic       changed
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_SETTLE,
    S_SAMPLE,
    S_RD_SETTLE,
    S_RD_SAMPLE,
    S_RD_ACK
  } state_t;

  localparam logic [3:0] SETTLE_LAST = 4'(SETTLE - 1);
  localparam logic [4:0] DEB         = 5'(DEBOUNCE);

  state_t     state, state_next;
  logic [3:0] scnt;
  logic [2:0] ptr;
  logic [3:0] cnt [8];

  logic       load_scan, load_rd, in_settle, settle_last;
  logic [2:0] ptr_inc, scan_ptr;
  logic [4:0] cnt_inc;

  assign dis         = 1'b0;
  assign rd_ack      = (state == S_RD_ACK);
  assign inh         = !(state inside {S_SETTLE, S_SAMPLE, S_RD_SETTLE, S_RD_SAMPLE});
  assign in_settle   = (state == S_SETTLE) || (state == S_RD_SETTLE);
  assign settle_last = (scnt == SETTLE_LAST);
  assign ptr_inc     = ptr + 3'd1;
  // A scan boundary leaving SAMPLE addresses the channel after the one just sampled.
  assign scan_ptr    = (state == S_SAMPLE) ? ptr_inc : ptr;
  assign cnt_inc     = {1'b0, cnt[ptr]} + 5'd1;

  // NOTE: every always_comb output gets a default first so no path infers a latch.
  always_comb begin
    state_next = state;
    load_scan  = 1'b0;
    load_rd    = 1'b0;
    case (state)
      S_IDLE, S_SAMPLE: begin
        if (rd_req) begin
          state_next = S_RD_SETTLE;
          load_rd    = 1'b1;
        end else if (en) begin
          state_next = S_SETTLE;
          load_scan  = 1'b1;
        end else begin
          state_next = S_IDLE;
        end
      end
      S_SETTLE:    if (settle_last) state_next = S_SAMPLE;
      S_RD_SETTLE: if (settle_last) state_next = S_RD_SAMPLE;
      S_RD_SAMPLE: state_next = S_RD_ACK;
      S_RD_ACK: begin
        // The requester is still dropping rd_req here, so only the scan may start.
        if (en) begin
          state_next = S_SETTLE;
          load_scan  = 1'b1;
        end else begin
          state_next = S_IDLE;
        end
      end
      default: state_next = S_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // sees pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= S_IDLE;
      scnt      <= '0;
      ptr       <= '0;
      abc       <= '0;
      rd_data   <= 1'b0;
      image     <= '0;
      scan_done <= 1'b0;
      changed   <= 1'b0;
      // NOTE: the debounce counters are a tiny register array, cleared on reset
      // so a fresh scan never inherits partial counts.
      for (int i = 0; i < 8; i++) cnt[i] <= '0;
    end else begin
      state     <= state_next;
      scan_done <= 1'b0;
      changed   <= 1'b0;
      scnt      <= (in_settle && !settle_last) ? scnt + 4'd1 : 4'd0;

      if (load_rd)        abc <= rd_addr;
      else if (load_scan) abc <= scan_ptr;

      if (state == S_RD_SAMPLE) rd_data <= z;

      if (state == S_SAMPLE) begin
        if (z == image[ptr]) begin
          cnt[ptr] <= '0;
        end else if (cnt_inc == DEB) begin
          image[ptr] <= z;
          cnt[ptr]   <= '0;
          changed    <= 1'b1;
        end else begin
          cnt[ptr] <= cnt_inc[3:0];
        end
        ptr       <= ptr_inc;
        scan_done <= (ptr == 3'd7);
      end
    end
  end

endmodule

// File: tb/tb_mc14512_scan_ctrl.sv
// Scoreboard bench for mc14512_scan_ctrl: stimulus queues expected responses,
// a monitor compares them when the DUT signals scan_done / rd_ack.
module tb_mc14512_scan_ctrl;

  typedef struct {
    logic [31:0] val;
    int          cyc;
  } exp_t;

  typedef struct {
    string       name;
    int          sel;
    logic [31:0] val;
  } probe_t;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;

  logic       en, rd_req, z, inh, dis, rd_ack, rd_data, scan_done, changed;
  logic [2:0] rd_addr, abc;
  logic [7:0] x, image;

  logic       en_f, rd_req_f, z_f, inh_f, dis_f, rd_ack_f, rd_data_f, scan_done_f, changed_f;
  logic [2:0] rd_addr_f, abc_f;
  logic [7:0] x_f, image_f;

  int cyc = 0;
  int n_pass = 0;
  int n_chk = 0;
  int chg_cnt = 0;
  int chg_f = 0;

  exp_t   q_done[$];
  exp_t   q_rd[$];
  exp_t   q_fdone[$];
  probe_t q_probe[$];

  // Behavioural mc14512: inhibit forces z low, otherwise the addressed input.
  assign z   = inh   ? 1'b0 : x[abc];
  assign z_f = inh_f ? 1'b0 : x_f[abc_f];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  mc14512_scan_ctrl #(.SETTLE(2), .DEBOUNCE(3)) u_dut (
    .clk(clk), .rst_n(rst_n), .en(en), .abc(abc), .inh(inh), .dis(dis), .z(z),
    .rd_req(rd_req), .rd_addr(rd_addr), .rd_ack(rd_ack), .rd_data(rd_data),
    .image(image), .scan_done(scan_done), .changed(changed)
  );

  mc14512_scan_ctrl #(.SETTLE(1), .DEBOUNCE(1)) u_fast (
    .clk(clk), .rst_n(rst_n), .en(en_f), .abc(abc_f), .inh(inh_f), .dis(dis_f), .z(z_f),
    .rd_req(rd_req_f), .rd_addr(rd_addr_f), .rd_ack(rd_ack_f), .rd_data(rd_data_f),
    .image(image_f), .scan_done(scan_done_f), .changed(changed_f)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
  endtask

  function automatic logic [31:0] probe_val(input int sel);
    case (sel)
      1:       return 32'(chg_cnt);
      2:       return 32'({abc, inh});
      3:       return 32'(rd_data);
      4:       return 32'({image, abc, inh, dis, rd_ack, rd_data, scan_done, changed});
      5:       return 32'(chg_f);
      6:       return 32'({abc_f, inh_f, dis_f, rd_ack_f, rd_data_f});
      7:       return 32'(q_done.size() + q_rd.size() + q_fdone.size());
      default: return 32'(image);
    endcase
  endfunction

  // Monitor: samples 1 time unit after the falling edge.
  initial begin
    exp_t   e;
    probe_t p;
    forever begin
      @(negedge clk);
      #1;
      if (scan_done) begin
        check("scan_done expected", 32'(q_done.size() > 0), 32'd1);
        if (q_done.size() > 0) begin
          e = q_done.pop_front();
          check("scan image", 32'(image), e.val);
          check("scan_done cycle", 32'(cyc), 32'(e.cyc));
        end
      end
      if (rd_ack) begin
        check("rd_ack expected", 32'(q_rd.size() > 0), 32'd1);
        if (q_rd.size() > 0) begin
          e = q_rd.pop_front();
          check("rd_data", 32'(rd_data), e.val);
          check("rd_ack cycle", 32'(cyc), 32'(e.cyc));
        end
      end
      if (scan_done_f) begin
        check("fast scan_done expected", 32'(q_fdone.size() > 0), 32'd1);
        if (q_fdone.size() > 0) begin
          e = q_fdone.pop_front();
          check("fast scan image", 32'(image_f), e.val);
          check("fast scan_done cycle", 32'(cyc), 32'(e.cyc));
        end
      end
      if (changed)   chg_cnt++;
      if (changed_f) chg_f++;
      while (q_probe.size() > 0) begin
        p = q_probe.pop_front();
        check(p.name, probe_val(p.sel), p.val);
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation exceeded time limit at cycle %0d", cyc);
    $fatal(1);
  end

  task automatic wait_until(input int c);
    while (cyc < c) @(negedge clk);
  endtask

  task automatic push_probe(input string name, input int sel, input logic [31:0] val);
    q_probe.push_back('{name, sel, val});
  endtask

  initial begin
    int b, b2, cf;
    en = 1'b0; rd_req = 1'b0; rd_addr = 3'd0; x = 8'h00;
    en_f = 1'b0; rd_req_f = 1'b0; rd_addr_f = 3'd0; x_f = 8'h00;

    repeat (2) @(negedge clk);
    x = 8'hA5; en = 1'b1; rst_n = 1'b1;
    b = cyc;
    // Static A5: three passes to debounce, 24 cycles per pass.
    q_done.push_back('{32'h00, b + 25});
    q_done.push_back('{32'h00, b + 49});
    q_done.push_back('{32'hA5, b + 73});
    wait_until(b + 74);
    push_probe("changed pulses after settling", 1, 32'd4);

    // Single-sample glitches on channel 3, separated by a clean pass.
    q_done.push_back('{32'hA5, b + 97});
    q_done.push_back('{32'hA5, b + 121});
    q_done.push_back('{32'hA5, b + 145});
    q_done.push_back('{32'hA5, b + 169});
    wait_until(b + 84);  x[3] = 1'b1;
    wait_until(b + 85);  x[3] = 1'b0;
    wait_until(b + 132); x[3] = 1'b1;
    wait_until(b + 133); x[3] = 1'b0;
    wait_until(b + 156); x[3] = 1'b1;
    wait_until(b + 157); x[3] = 1'b0;
    wait_until(b + 170);
    push_probe("changed pulses after glitches", 1, 32'd4);

    // Direct read of channel 6 during the settle of channel 1.
    wait_until(b + 173);
    rd_req = 1'b1; rd_addr = 3'd6; x = 8'hE5;
    q_rd.push_back('{32'd1, b + 178});
    q_done.push_back('{32'hA5, b + 197});
    wait_until(b + 176); rd_addr = 3'd4;
    wait_until(b + 178); rd_req = 1'b0; x = 8'hA5;
    wait_until(b + 179);
    push_probe("scan resumes at channel 2", 2, 32'({3'd2, 1'b0}));
    wait_until(b + 180);
    push_probe("rd_data held", 3, 32'd1);

    // Drop en during the settle of channel 4.
    wait_until(b + 210); en = 1'b0;
    wait_until(b + 213);
    push_probe("idle after en drop", 2, 32'({3'd4, 1'b1}));
    wait_until(b + 216); en = 1'b1;
    q_done.push_back('{32'hA5, b + 226});
    wait_until(b + 217);
    push_probe("resume at channel 5", 2, 32'({3'd5, 1'b0}));

    // Asynchronous reset in the middle of a scan.
    wait_until(b + 231);
    @(posedge clk);
    #2 rst_n = 1'b0;
    push_probe("async reset values", 4, 32'({8'h00, 3'd0, 1'b1, 5'b00000}));
    wait_until(b + 234);
    rst_n = 1'b1;
    b2 = cyc;
    q_done.push_back('{32'h00, b2 + 25});
    wait_until(b2 + 25); en = 1'b0;

    // Fast instance: SETTLE=1, DEBOUNCE=1, 16-cycle passes.
    wait_until(b2 + 30);
    cf = cyc;
    x_f = 8'h3C; en_f = 1'b1;
    q_fdone.push_back('{32'h3C, cf + 17});
    q_fdone.push_back('{32'hC3, cf + 33});
    wait_until(cf + 17); x_f = 8'hC3;
    wait_until(cf + 33); en_f = 1'b0;
    wait_until(cf + 37);
    push_probe("fast idle outputs", 6, 32'({3'd0, 1'b1, 3'b000}));
    push_probe("fast changed pulses", 5, 32'd12);

    wait_until(cf + 40);
    push_probe("scoreboard drained", 7, 32'd0);
    wait_until(cf + 42);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
